// File: rtl/exu_decode_stage_pkg.sv
// Shared decode constants: DECINFO layout and group codes, opcode/funct encodings, FSM states.
package exu_decode_stage_pkg;

  localparam int RFIDX_WIDTH   = 5;
  localparam int DECINFO_WIDTH = 16;

  // info[2:0] holds the group; zero means "no group" (used for illegal words)
  localparam logic [2:0] GRP_NONE   = 3'd0;
  localparam logic [2:0] GRP_ALU    = 3'd1;
  localparam logic [2:0] GRP_BJP    = 3'd2;
  localparam logic [2:0] GRP_MULDIV = 3'd3;
  localparam logic [2:0] GRP_AGU    = 3'd4;

  localparam int ALU_ADD = 3, ALU_SUB = 4, ALU_XOR = 5, ALU_SLL = 6, ALU_SRL = 7, ALU_SRA = 8;
  localparam int ALU_OR = 9, ALU_AND = 10, ALU_SLT = 11, ALU_SLTU = 12, ALU_LUI = 13;
  localparam int ALU_OP2IMM = 14, ALU_OP1PC = 15;

  localparam int BJP_JUMP = 3, BJP_BEQ = 4, BJP_BNE = 5, BJP_BLT = 6, BJP_BGE = 7;
  localparam int BJP_BLTU = 8, BJP_BGEU = 9, BJP_BXX = 10, BJP_PRDT = 11;

  // MULDIV ops occupy MD_MUL..MD_MUL+7 indexed directly by funct3
  localparam int MD_MUL = 3;

  localparam int AGU_LOAD = 3, AGU_STORE = 4, AGU_SIZE_LSB = 5, AGU_USIGN = 7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

endpackage

// File: rtl/exu_decode_core.sv
// Combinational RV32I(+M) decoder: instruction word in, DECINFO/indices/enables/immediates out.
module exu_decode_core
  import exu_decode_stage_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int HAS_MULDIV    = 1,
  parameter int SHAMT_CHECK   = 1,
  parameter int RDX0_SUPPRESS = 1
) (
  input  logic [31:0]              instr,
  input  logic                     prdt_taken,
  output logic [RFIDX_WIDTH-1:0]   rs1idx,
  output logic [RFIDX_WIDTH-1:0]   rs2idx,
  output logic [RFIDX_WIDTH-1:0]   rdidx,
  output logic                     rs1en,
  output logic                     rs2en,
  output logic                     rdwen,
  output logic [DECINFO_WIDTH-1:0] info,
  output logic [XLEN-1:0]          imm,
  output logic                     illegal,
  output logic                     bjp,
  output logic                     jal,
  output logic                     jalr,
  output logic                     bxx,
  output logic [XLEN-1:0]          bjp_imm
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic op_f7_ok, md_op, known_op, shamt_bad;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32, bimm32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign is_lui    = (opc == OPC_LUI);
  assign is_auipc  = (opc == OPC_AUIPC);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_opimm  = (opc == OPC_OPIMM);
  assign is_op     = (opc == OPC_OP);
  assign known_op  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_opimm | is_op;

  always_comb begin
    op_f7_ok = 1'b0;
    case (f7)
      F7_BASE:   op_f7_ok = 1'b1;
      F7_ALT:    op_f7_ok = (f3 == F3_ADD) || (f3 == F3_SR);
      F7_MULDIV: op_f7_ok = (HAS_MULDIV != 0);
      default:   op_f7_ok = 1'b0;
    endcase
  end

  assign md_op     = is_op & (f7 == F7_MULDIV) & (HAS_MULDIV != 0);
  assign shamt_bad = (SHAMT_CHECK != 0) & is_opimm & ((f3 == F3_SLL) | (f3 == F3_SR)) & instr[25];

  assign illegal = (instr == 32'h0) | (instr == 32'hFFFF_FFFF) | (instr[1:0] != 2'b11) | ~known_op
                 | (is_op & ~op_f7_ok) | shamt_bad
                 | (is_load & ((f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111)))
                 | (is_store & (f3 >= 3'b011))
                 | (is_branch & ((f3 == 3'b010) | (f3 == 3'b011)))
                 | (is_jalr & (f3 != 3'b000));

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm32 = 32'h0;
    if (is_opimm | is_load | is_jalr) imm32 = imm_i;
    else if (is_store)                imm32 = imm_s;
    else if (is_branch)               imm32 = imm_b;
    else if (is_lui | is_auipc)       imm32 = imm_u;
    else if (is_jal)                  imm32 = imm_j;
    bimm32 = 32'h0;
    if (is_jalr)        bimm32 = imm_i;
    else if (is_branch) bimm32 = imm_b;
    else if (is_jal)    bimm32 = imm_j;
  end

  assign imm     = XLEN'($signed(imm32));
  assign bjp_imm = XLEN'($signed(bimm32));

  always_comb begin
    info = '0;
    if (is_lui) begin
      info[2:0] = GRP_ALU; info[ALU_LUI] = 1'b1; info[ALU_OP2IMM] = 1'b1;
    end else if (is_auipc) begin
      info[2:0] = GRP_ALU; info[ALU_ADD] = 1'b1; info[ALU_OP2IMM] = 1'b1; info[ALU_OP1PC] = 1'b1;
    end else if (is_jal | is_jalr) begin
      info[2:0] = GRP_BJP; info[BJP_JUMP] = 1'b1; info[BJP_PRDT] = prdt_taken;
    end else if (is_branch) begin
      info[2:0] = GRP_BJP; info[BJP_BXX] = 1'b1; info[BJP_PRDT] = prdt_taken;
      case (f3)
        3'b000:  info[BJP_BEQ]  = 1'b1;
        3'b001:  info[BJP_BNE]  = 1'b1;
        3'b100:  info[BJP_BLT]  = 1'b1;
        3'b101:  info[BJP_BGE]  = 1'b1;
        3'b110:  info[BJP_BLTU] = 1'b1;
        3'b111:  info[BJP_BGEU] = 1'b1;
        default: ;
      endcase
    end else if (is_load | is_store) begin
      info[2:0] = GRP_AGU; info[AGU_LOAD] = is_load; info[AGU_STORE] = is_store;
      info[AGU_SIZE_LSB +: 2] = f3[1:0]; info[AGU_USIGN] = is_load & f3[2];
    end else if (md_op) begin
      info[2:0] = GRP_MULDIV; info[MD_MUL + int'(f3)] = 1'b1;
    end else if (is_op | is_opimm) begin
      info[2:0] = GRP_ALU; info[ALU_OP2IMM] = is_opimm;
      case (f3)
        F3_ADD:  if (is_op && f7 == F7_ALT) info[ALU_SUB] = 1'b1; else info[ALU_ADD] = 1'b1;
        F3_SLL:  info[ALU_SLL]  = 1'b1;
        F3_SLT:  info[ALU_SLT]  = 1'b1;
        F3_SLTU: info[ALU_SLTU] = 1'b1;
        F3_XOR:  info[ALU_XOR]  = 1'b1;
        F3_SR:   if (instr[30]) info[ALU_SRA] = 1'b1; else info[ALU_SRL] = 1'b1;
        F3_OR:   info[ALU_OR]   = 1'b1;
        default: info[ALU_AND]  = 1'b1;
      endcase
    end
    if (illegal) info = '0;
  end

  assign rs1idx = instr[19:15];
  assign rs2idx = instr[24:20];
  assign rdidx  = instr[11:7];
  assign rs1en  = is_jalr | is_branch | is_load | is_store | is_opimm | is_op;
  assign rs2en  = is_branch | is_store | is_op;
  assign rdwen  = ~illegal & (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op)
                & ~((RDX0_SUPPRESS != 0) & (instr[11:7] == 5'd0));
  assign bjp    = ~illegal & (is_jal | is_jalr | is_branch);
  assign jal    = ~illegal & is_jal;
  assign jalr   = ~illegal & is_jalr;
  assign bxx    = ~illegal & is_branch;

endmodule

// File: rtl/exu_decode_stage.sv
// Registered decode stage: output register plus one-entry skid so i_ready comes straight from a flop.
// Latency 1 cycle; flush empties both entries; saturating count of delivered illegal words.
module exu_decode_stage
  import exu_decode_stage_pkg::*;
#(
  parameter int PC_SIZE       = 32,
  parameter int XLEN          = 32,
  parameter int HAS_MULDIV    = 1,
  parameter int SHAMT_CHECK   = 1,
  parameter int RDX0_SUPPRESS = 1,
  parameter int ILLCNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [31:0]              i_instr,
  input  logic [PC_SIZE-1:0]       i_pc,
  input  logic                     i_prdt_taken,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [RFIDX_WIDTH-1:0]   o_rs1idx,
  output logic [RFIDX_WIDTH-1:0]   o_rs2idx,
  output logic [RFIDX_WIDTH-1:0]   o_rdidx,
  output logic                     o_rs1en,
  output logic                     o_rs2en,
  output logic                     o_rdwen,
  output logic [DECINFO_WIDTH-1:0] o_info,
  output logic [XLEN-1:0]          o_imm,
  output logic [PC_SIZE-1:0]       o_pc,
  output logic                     o_illegal,
  output logic                     o_bjp,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic                     o_bxx,
  output logic [XLEN-1:0]          o_bjp_imm,
  output logic [ILLCNT_WIDTH-1:0]  o_illcnt
);
  typedef struct packed {
    logic [RFIDX_WIDTH-1:0]   rs1idx;
    logic [RFIDX_WIDTH-1:0]   rs2idx;
    logic [RFIDX_WIDTH-1:0]   rdidx;
    logic                     rs1en;
    logic                     rs2en;
    logic                     rdwen;
    logic [DECINFO_WIDTH-1:0] info;
    logic [XLEN-1:0]          imm;
    logic [PC_SIZE-1:0]       pc;
    logic                     illegal;
    logic                     bjp;
    logic                     jal;
    logic                     jalr;
    logic                     bxx;
    logic [XLEN-1:0]          bjp_imm;
  } pay_t;

  pay_t   dec, out_q, skid_q;
  state_e state;
  logic   vld_q, rdy_q, acc, deq;
  logic [ILLCNT_WIDTH-1:0] illcnt_q;

  exu_decode_core #(
    .XLEN(XLEN), .HAS_MULDIV(HAS_MULDIV), .SHAMT_CHECK(SHAMT_CHECK), .RDX0_SUPPRESS(RDX0_SUPPRESS)
  ) u_core (
    .instr(i_instr), .prdt_taken(i_prdt_taken),
    .rs1idx(dec.rs1idx), .rs2idx(dec.rs2idx), .rdidx(dec.rdidx),
    .rs1en(dec.rs1en), .rs2en(dec.rs2en), .rdwen(dec.rdwen),
    .info(dec.info), .imm(dec.imm), .illegal(dec.illegal),
    .bjp(dec.bjp), .jal(dec.jal), .jalr(dec.jalr), .bxx(dec.bxx), .bjp_imm(dec.bjp_imm)
  );
  assign dec.pc = i_pc;

  assign acc = i_valid & rdy_q;
  assign deq = vld_q & o_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b1;
      out_q    <= '0;
      skid_q   <= '0;
      illcnt_q <= '0;
    end else begin
      // a dequeue in a flush cycle is discarded, so it is not counted
      if (deq && !i_flush && out_q.illegal && illcnt_q != {ILLCNT_WIDTH{1'b1}})
        illcnt_q <= illcnt_q + ILLCNT_WIDTH'(1);
      if (i_flush) begin
        state <= ST_EMPTY;
        vld_q <= 1'b0;
        rdy_q <= 1'b1;
      end else begin
        case (state)
          ST_EMPTY: if (acc) begin
            out_q <= dec; vld_q <= 1'b1; state <= ST_ONE;
          end
          ST_ONE: begin
            if (acc && deq) out_q <= dec;
            else if (acc) begin
              skid_q <= dec; rdy_q <= 1'b0; state <= ST_TWO;
            end else if (deq) begin
              vld_q <= 1'b0; state <= ST_EMPTY;
            end
          end
          ST_TWO: if (deq) begin
            out_q <= skid_q; rdy_q <= 1'b1; state <= ST_ONE;
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

  assign i_ready   = rdy_q;
  assign o_valid   = vld_q;
  assign o_rs1idx  = out_q.rs1idx;
  assign o_rs2idx  = out_q.rs2idx;
  assign o_rdidx   = out_q.rdidx;
  assign o_rs1en   = out_q.rs1en;
  assign o_rs2en   = out_q.rs2en;
  assign o_rdwen   = out_q.rdwen;
  assign o_info    = out_q.info;
  assign o_imm     = out_q.imm;
  assign o_pc      = out_q.pc;
  assign o_illegal = out_q.illegal;
  assign o_bjp     = out_q.bjp;
  assign o_jal     = out_q.jal;
  assign o_jalr    = out_q.jalr;
  assign o_bxx     = out_q.bxx;
  assign o_bjp_imm = out_q.bjp_imm;
  assign o_illcnt  = illcnt_q;

endmodule

// File: tb/tb_exu_decode_stage.sv
// Bench for exu_decode_stage: default instance plus a no-M, 4-bit-counter instance fed the same stimulus.
module tb_exu_decode_stage;
  import exu_decode_stage_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  logic i_valid = 1'b0, i_prdt_taken = 1'b0, i_flush = 1'b0, o_ready = 1'b1;
  logic [31:0] i_instr = 32'h0, i_pc = 32'h0;

  logic i_ready, o_valid, o_rs1en, o_rs2en, o_rdwen, o_illegal, o_bjp, o_jal, o_jalr, o_bxx;
  logic [4:0] o_rs1idx, o_rs2idx, o_rdidx;
  logic [DECINFO_WIDTH-1:0] o_info;
  logic [31:0] o_imm, o_pc, o_bjp_imm;
  logic [15:0] o_illcnt;

  logic n_i_ready, n_o_valid, n_rs1en, n_rs2en, n_rdwen, n_illegal, n_bjp, n_jal, n_jalr, n_bxx;
  logic [4:0] n_rs1idx, n_rs2idx, n_rdidx;
  logic [DECINFO_WIDTH-1:0] n_info;
  logic [31:0] n_imm, n_pc, n_bjp_imm;
  logic [3:0] n_illcnt;

  always #5 clk = ~clk;

  exu_decode_stage u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_prdt_taken(i_prdt_taken), .i_flush(i_flush), .o_valid(o_valid), .o_ready(o_ready),
    .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx), .o_rdidx(o_rdidx), .o_rs1en(o_rs1en),
    .o_rs2en(o_rs2en), .o_rdwen(o_rdwen), .o_info(o_info), .o_imm(o_imm), .o_pc(o_pc),
    .o_illegal(o_illegal), .o_bjp(o_bjp), .o_jal(o_jal), .o_jalr(o_jalr), .o_bxx(o_bxx),
    .o_bjp_imm(o_bjp_imm), .o_illcnt(o_illcnt)
  );

  exu_decode_stage #(.HAS_MULDIV(0), .ILLCNT_WIDTH(4)) u_nomd (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(n_i_ready), .i_instr(i_instr), .i_pc(i_pc),
    .i_prdt_taken(i_prdt_taken), .i_flush(i_flush), .o_valid(n_o_valid), .o_ready(o_ready),
    .o_rs1idx(n_rs1idx), .o_rs2idx(n_rs2idx), .o_rdidx(n_rdidx), .o_rs1en(n_rs1en),
    .o_rs2en(n_rs2en), .o_rdwen(n_rdwen), .o_info(n_info), .o_imm(n_imm), .o_pc(n_pc),
    .o_illegal(n_illegal), .o_bjp(n_bjp), .o_jal(n_jal), .o_jalr(n_jalr), .o_bxx(n_bxx),
    .o_bjp_imm(n_bjp_imm), .o_illcnt(n_illcnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic        prdt;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  en;     // {rs1en, rs2en, rdwen}
    logic [15:0] info;
    logic [31:0] imm, bimm;
    logic [3:0]  flags;  // {bjp, jal, jalr, bxx}
    logic        ill, ill_nomd;
  } vec_t;

  vec_t vec[15];
  int n_cmp = 0, n_bad = 0;
  logic [3:0] got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Offer one instruction; returns just after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic prdt, input logic [31:0] pc);
    int w;
    w = 0;
    @(negedge clk);
    while (!i_ready && w < 20) begin @(negedge clk); w++; end
    chk("send_ready", {63'd0, i_ready}, 64'd1);
    i_valid = 1'b1; i_instr = ins; i_prdt_taken = prdt; i_pc = pc;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  function automatic logic [31:0] addi_x1(input logic [11:0] k);
    return {k, 20'h00093};
  endfunction

  initial begin
    //          instr         prdt  rs1    rs2    rd     en      info      imm           bimm          flags    ill   nomd
    vec[0]  = '{32'h00500093, 1'b0, 5'd0,  5'd5,  5'd1,  3'b101, 16'h4009, 32'h00000005, 32'h0,        4'b0000, 1'b0, 1'b0};
    vec[1]  = '{32'h022081B3, 1'b0, 5'd1,  5'd2,  5'd3,  3'b111, 16'h000B, 32'h0,        32'h0,        4'b0000, 1'b0, 1'b1};
    vec[2]  = '{32'h02009093, 1'b0, 5'd1,  5'd0,  5'd1,  3'b100, 16'h0000, 32'h00000020, 32'h0,        4'b0000, 1'b1, 1'b1};
    vec[3]  = '{32'h00100013, 1'b0, 5'd0,  5'd1,  5'd0,  3'b100, 16'h4009, 32'h00000001, 32'h0,        4'b0000, 1'b0, 1'b0};
    vec[4]  = '{32'h407302B3, 1'b0, 5'd6,  5'd7,  5'd5,  3'b111, 16'h0011, 32'h0,        32'h0,        4'b0000, 1'b0, 1'b0};
    vec[5]  = '{32'h12345137, 1'b0, 5'd8,  5'd3,  5'd2,  3'b001, 16'h6001, 32'h12345000, 32'h0,        4'b0000, 1'b0, 1'b0};
    vec[6]  = '{32'h008000EF, 1'b0, 5'd0,  5'd8,  5'd1,  3'b001, 16'h000A, 32'h00000008, 32'h00000008, 4'b1100, 1'b0, 1'b0};
    vec[7]  = '{32'hFE208EE3, 1'b1, 5'd1,  5'd2,  5'd29, 3'b110, 16'h0C12, 32'hFFFFFFFC, 32'hFFFFFFFC, 4'b1001, 1'b0, 1'b0};
    vec[8]  = '{32'h00C1A203, 1'b0, 5'd3,  5'd12, 5'd4,  3'b101, 16'h004C, 32'h0000000C, 32'h0,        4'b0000, 1'b0, 1'b0};
    vec[9]  = '{32'hFE532C23, 1'b0, 5'd6,  5'd5,  5'd24, 3'b110, 16'h0054, 32'hFFFFFFF8, 32'h0,        4'b0000, 1'b0, 1'b0};
    vec[10] = '{32'h004110E7, 1'b0, 5'd2,  5'd4,  5'd1,  3'b100, 16'h0000, 32'h00000004, 32'h00000004, 4'b0000, 1'b1, 1'b1};
    vec[11] = '{32'h00008067, 1'b0, 5'd1,  5'd0,  5'd0,  3'b100, 16'h000A, 32'h0,        32'h0,        4'b1010, 1'b0, 1'b0};
    vec[12] = '{32'hFFFFFFFF, 1'b0, 5'd31, 5'd31, 5'd31, 3'b000, 16'h0000, 32'h0,        32'h0,        4'b0000, 1'b1, 1'b1};
    vec[13] = '{32'h40315093, 1'b0, 5'd2,  5'd3,  5'd1,  3'b101, 16'h4101, 32'h00000403, 32'h0,        4'b0000, 1'b0, 1'b0};
    vec[14] = '{32'h40004033, 1'b0, 5'd0,  5'd0,  5'd0,  3'b110, 16'h0000, 32'h0,        32'h0,        4'b0000, 1'b1, 1'b1};

    do_reset();
    @(negedge clk);
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_i_ready", {63'd0, i_ready}, 64'd1);
    chk("rst_illcnt", {48'd0, o_illcnt}, 64'd0);
    chk("rst_info", {48'd0, o_info}, 64'd0);
    chk("rst_imm", {32'd0, o_imm}, 64'd0);
    chk("rst_pc", {32'd0, o_pc}, 64'd0);

    o_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(vec[i].instr, vec[i].prdt, 32'h100 + 32'(i * 4));
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {63'd0, o_valid}, 64'd1);
      chk($sformatf("v%0d_rs1", i), {59'd0, o_rs1idx}, {59'd0, vec[i].rs1});
      chk($sformatf("v%0d_rs2", i), {59'd0, o_rs2idx}, {59'd0, vec[i].rs2});
      chk($sformatf("v%0d_rd", i), {59'd0, o_rdidx}, {59'd0, vec[i].rd});
      chk($sformatf("v%0d_en", i), {61'd0, o_rs1en, o_rs2en, o_rdwen}, {61'd0, vec[i].en});
      chk($sformatf("v%0d_info", i), {48'd0, o_info}, {48'd0, vec[i].info});
      chk($sformatf("v%0d_imm", i), {32'd0, o_imm}, {32'd0, vec[i].imm});
      chk($sformatf("v%0d_bjp_imm", i), {32'd0, o_bjp_imm}, {32'd0, vec[i].bimm});
      chk($sformatf("v%0d_flags", i), {60'd0, o_bjp, o_jal, o_jalr, o_bxx}, {60'd0, vec[i].flags});
      chk($sformatf("v%0d_illegal", i), {63'd0, o_illegal}, {63'd0, vec[i].ill});
      chk($sformatf("v%0d_pc", i), {32'd0, o_pc}, {32'd0, 32'h100 + 32'(i * 4)});
      chk($sformatf("v%0d_nomd_illegal", i), {63'd0, n_illegal}, {63'd0, vec[i].ill_nomd});
    end
    @(negedge clk);
    chk("table_illcnt", {48'd0, o_illcnt}, 64'd4);
    chk("table_nomd_illcnt", {60'd0, n_illcnt}, 64'd5);

    // mul with and without M support
    do_reset();
    send(32'h022081B3, 1'b0, 32'h200);
    @(negedge clk);
    chk("mul_info", {48'd0, o_info}, 64'h000B);
    chk("mul_nomd_info", {48'd0, n_info}, 64'd0);
    chk("mul_nomd_rdwen", {63'd0, n_rdwen}, 64'd0);
    chk("mul_nomd_illegal", {63'd0, n_illegal}, 64'd1);
    @(negedge clk);
    chk("mul_nomd_illcnt", {60'd0, n_illcnt}, 64'd1);
    chk("mul_illcnt", {48'd0, o_illcnt}, 64'd0);

    // back-pressure: A in OUT, B in SKID, C held off
    do_reset();
    o_ready = 1'b0;
    send(addi_x1(12'd1), 1'b0, 32'h300);
    send(addi_x1(12'd2), 1'b0, 32'h304);
    @(negedge clk);
    i_valid = 1'b1; i_instr = addi_x1(12'd3); i_pc = 32'h308;
    chk("bp_i_ready_two", {63'd0, i_ready}, 64'd0);
    chk("bp_out_a", {32'd0, o_imm}, 64'd1);
    @(negedge clk);
    chk("bp_i_ready_held", {63'd0, i_ready}, 64'd0);
    chk("bp_out_stable", {32'd0, o_imm}, 64'd1);
    o_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 10; k++) begin
      logic pending;
      if (o_valid) got.push_back(o_imm[3:0]);
      pending = i_valid && i_ready;
      @(posedge clk); #1;
      if (pending) i_valid = 1'b0;
      @(negedge clk);
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      if (k < got.size()) chk($sformatf("bp_order%0d", k), {60'd0, got[k]}, 64'(k + 1));

    // flush in TWO with D offered: nothing survives
    do_reset();
    o_ready = 1'b0;
    send(addi_x1(12'd4), 1'b0, 32'h400);
    send(addi_x1(12'd5), 1'b0, 32'h404);
    @(negedge clk);
    i_flush = 1'b1; i_valid = 1'b1; i_instr = addi_x1(12'd6);
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("flush_two_o_valid", {63'd0, o_valid}, 64'd0);
    chk("flush_two_i_ready", {63'd0, i_ready}, 64'd1);
    // flush in ONE: illegal OUT dequeued and new word offered, both dropped
    send(32'h0, 1'b0, 32'h408);
    @(negedge clk);
    o_ready = 1'b1; i_flush = 1'b1; i_valid = 1'b1; i_instr = addi_x1(12'd8);
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("flush_one_o_valid", {63'd0, o_valid}, 64'd0);
    chk("flush_one_illcnt", {48'd0, o_illcnt}, 64'd0);
    send(addi_x1(12'd7), 1'b0, 32'h40C);
    @(negedge clk);
    chk("flush_e_valid", {63'd0, o_valid}, 64'd1);
    chk("flush_e_imm", {32'd0, o_imm}, 64'd7);
    @(negedge clk);
    chk("flush_e_drained", {63'd0, o_valid}, 64'd0);

    // counter saturation
    do_reset();
    o_ready = 1'b1;
    for (int k = 0; k < 17; k++) send(32'h0, 1'b0, 32'h500);
    @(negedge clk); @(negedge clk);
    chk("sat_illcnt16", {48'd0, o_illcnt}, 64'd17);
    chk("sat_illcnt4", {60'd0, n_illcnt}, 64'd15);

    // reset with two held entries and a competing offer
    o_ready = 1'b0;
    send(addi_x1(12'd9), 1'b0, 32'h600);
    send(addi_x1(12'd10), 1'b0, 32'h604);
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; i_instr = addi_x1(12'd11);
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("rst2_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst2_i_ready", {63'd0, i_ready}, 64'd1);
    chk("rst2_illcnt", {48'd0, o_illcnt}, 64'd0);
    chk("rst2_nomd_illcnt", {60'd0, n_illcnt}, 64'd0);
    chk("rst2_imm", {32'd0, o_imm}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exu_decode_stage.md
Name: exu_decode_stage

Overview:
Registered, parametrised RV32I(+M) decode stage between IFU and the EXU dispatch.
- Accepts raw instruction/PC/prediction over a valid/ready handshake.
- Decodes it into the team's DECINFO bus, register indices/enables and immediates.
- Presents the result from an output register backed by a one-entry skid buffer, so the upstream ready is fully registered.
- Adds flush, configurable M-extension support, shamt-legality checking, rd=x0 write suppression, and a saturating illegal-instruction counter.

Parameters:
- PC_SIZE, 32, width of PC fields.
- XLEN, 32, width of immediates.
- HAS_MULDIV, 1, 1 = decode M extension; 0 = M encodings flagged illegal and muldiv group never produced.
- SHAMT_CHECK, 1, 1 = SLLI/SRLI/SRAI with instr[25]=1 is illegal.
- RDX0_SUPPRESS, 1, 1 = o_rdwen forced 0 when rd=x0.
- ILLCNT_WIDTH, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; everything on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  upstream instruction valid.
- i_ready  out  1  stage can accept.
- i_instr  in  32  instruction word.
- i_pc  in  PC_SIZE  instruction PC.
- i_prdt_taken  in  1  branch-predicted-taken.
- i_flush  in  1  discard all held and incoming instructions.
- o_valid  out  1  decoded instruction valid.
- o_ready  in  1  downstream accepts.
- o_rs1idx, o_rs2idx, o_rdidx  out  5 each  register indices.
- o_rs1en, o_rs2en, o_rdwen  out  1 each  register enables.
- o_info  out  DECINFO_WIDTH  group-encoded decode info (BJP/ALU/MULDIV/AGU).
- o_imm  out  XLEN  selected immediate.
- o_pc  out  PC_SIZE  instruction PC.
- o_illegal  out  1  illegal instruction.
- o_bjp, o_jal, o_jalr, o_bxx  out  1 each  branch/jump class flags.
- o_bjp_imm  out  XLEN  branch/jump offset.
- o_illcnt  out  ILLCNT_WIDTH  count of illegal instructions delivered.

Behaviour:
- Decode is combinational on i_instr and is captured at acceptance (i_valid & i_ready). All o_* payload fields are registered.
- Latency: accepted in cycle N → o_valid in N+1.
- Storage: output register (OUT) plus skid entry (SKID). Three states: EMPTY, ONE (OUT valid), TWO (OUT and SKID valid).
- i_ready = ~SKID.valid, driven straight from a flop; no combinational path from o_ready.
- Transitions, with acc = i_valid & i_ready and deq = o_valid & o_ready:
  - EMPTY + acc → ONE.
  - ONE + acc & ~deq → TWO.
  - ONE + acc & deq → ONE (OUT reloaded with the new instruction).
  - ONE + ~acc & deq → EMPTY.
  - TWO + deq → ONE (SKID moves to OUT). No acceptance is possible in TWO.
- Program order is strictly preserved. OUT payload is stable while o_valid & ~o_ready.
- Flush: i_flush=1 → next state EMPTY, SKID and OUT valid cleared. An instruction offered in the flush cycle is dropped, as is any dequeue. The counter does not count dropped instructions.
- Illegal conditions, ORed:
  - all-zeros pattern or all-ones word;
  - opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP};
  - OP with funct7 not in {0000000, 0100000 (ADD/SUB, SRL/SRA only), 0000001 (if HAS_MULDIV)};
  - shamt violation when SHAMT_CHECK=1;
  - LOAD funct3 in {011, 110, 111};
  - STORE funct3 ≥ 011;
  - BRANCH funct3 in {010, 011};
  - JALR funct3 ≠ 000;
  - instr[1:0] ≠ 11.
- Illegal instructions still flow through: o_info = 0, o_rdwen = 0, o_illegal = 1.
- Immediates: I/S/B/U/J selected by class, sign-extended to XLEN. o_bjp_imm uses I for JALR, B for branches, J for JAL, else 0.
- o_rs2en only for BRANCH/STORE/OP. o_rs1en is 0 for LUI/AUIPC/JAL.
- o_illcnt: +1 on each deq with o_illegal=1. Saturates at all-ones with no wrap.
- Reset values: o_valid=0; i_ready=1; all payload outputs 0; o_illcnt=0; state EMPTY. Reset mid-operation discards everything and wins over flush and handshakes.

Decomposition:
- defines.v holds: DECINFO field positions/widths and group codes; opcode constants (7-bit) and funct3/funct7 constants; RFIDX_WIDTH.
- Sub-module exu_decode_core (purely combinational, carries HAS_MULDIV/SHAMT_CHECK/RDX0_SUPPRESS): instr/pc/prdt in → decoded payload out.
- Top level holds only the OUT/SKID registers, the state control, flush handling and the counter.

Test Plan:
1. addi x1,x0,5 (0x00500093), PC 0x100, o_ready=1 → next cycle o_valid=1, o_rdidx=1, o_rs1en=1, o_rs2en=0, o_imm=5, ALU ADD+OP2IMM set, o_illegal=0.
2. mul x3,x1,x2 (0x022081B3): HAS_MULDIV=1 → MULDIV group, MUL bit set. HAS_MULDIV=0 → o_illegal=1, o_info=0, o_rdwen=0, o_illcnt=1.
3. slli x1,x1,32 (0x02009093), SHAMT_CHECK=1 → o_illegal=1. addi x0,x0,1 with RDX0_SUPPRESS=1 → o_rdwen=0, o_illegal=0.
4. Back-pressure: o_ready=0, offer A,B,C on consecutive cycles → A in OUT, B in SKID, i_ready=0 while C is held. Release o_ready → A,B,C delivered in order with no duplicates.
5. Flush while in TWO, with D offered the same cycle → o_valid=0 next cycle, i_ready=1. D never appears; the next accepted E is delivered normally.
6. ILLCNT_WIDTH=4, deliver 17 words of 0x00000000 → o_illcnt=15. Assert rst with held entries → o_valid=0, o_illcnt=0, i_ready=1 the next cycle.
